// File: rtl/program_sequencer.sv
// Fetch sequencer for NUM_PROGS programs: latches a program on req, steps pc until its done address, then acks.
// One edge from req to the first pc; req held during DONE keeps ack high until the requester drops it.
module program_sequencer #(
    parameter int PC_BITS   = 10,
    parameter int TGT_BITS  = 8,
    parameter int NUM_PROGS = 3,
    parameter int SEL_BITS  = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req,
    input  logic [SEL_BITS-1:0]            prog_sel,
    input  logic [NUM_PROGS*PC_BITS-1:0]   start_addrs,
    input  logic [NUM_PROGS*PC_BITS-1:0]   done_addrs,
    input  logic                           next_ins,
    input  logic                           stall,
    input  logic                           jump_flag,
    input  logic                           jump_rel,
    input  logic [TGT_BITS-1:0]            target,
    output logic [PC_BITS-1:0]             pc,
    output logic                           ack,
    output logic                           busy,
    output logic                           err,
    output logic [CNT_BITS-1:0]            cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [PC_BITS-1:0]    pc_q;
    logic [SEL_BITS-1:0]   sel_q;
    logic                  ack_q;
    logic                  busy_q;
    logic                  err_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic [PC_BITS-1:0]    start_pc;
    logic [PC_BITS-1:0]    done_pc;
    logic [PC_BITS-1:0]    rel_off;
    logic [PC_BITS-1:0]    abs_pc;
    logic [CNT_BITS-1:0]   cnt_d;
    logic                  sel_ok;

    assign sel_ok = (int'(prog_sel) < NUM_PROGS);

    // New selection comes from the live prog_sel; the done address uses the latched index.
    always_comb begin
        start_pc = '0;
        done_pc  = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (prog_sel == SEL_BITS'(i)) begin
                start_pc = start_addrs[i*PC_BITS +: PC_BITS];
            end
            if (sel_q == SEL_BITS'(i)) begin
                done_pc = done_addrs[i*PC_BITS +: PC_BITS];
            end
        end
    end

    generate
        if (PC_BITS > TGT_BITS) begin : g_ext
            assign rel_off = {{(PC_BITS-TGT_BITS){target[TGT_BITS-1]}}, target};
            assign abs_pc  = {{(PC_BITS-TGT_BITS){1'b0}}, target};
        end else begin : g_trunc
            assign rel_off = target[PC_BITS-1:0];
            assign abs_pc  = target[PC_BITS-1:0];
        end
    endgenerate

    assign cnt_d = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + CNT_BITS'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (sel_ok) begin
                            pc_q    <= start_pc;
                            sel_q   <= prog_sel;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            err_q   <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    // Done check wins over every advance input on the exiting edge.
                    if (pc_q == done_pc) begin
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (stall || !next_ins) begin
                        pc_q <= pc_q;
                    end else if (jump_flag && jump_rel) begin
                        pc_q <= pc_q + rel_off;
                    end else if (jump_flag) begin
                        pc_q <= abs_pc;
                    end else begin
                        pc_q <= pc_q + PC_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench: default-size sequencer (directed + random) and a 4-bit-pc / 3-bit-counter instance for wrap and saturation.
module tb_program_sequencer;
    localparam int PW_A = 10;
    localparam int PW_B = 4;
    localparam int CW_A = 16;
    localparam int CW_B = 3;
    localparam int NP   = 3;

    logic clock = 1'b0;
    logic reset;
    logic req_a, req_b;
    logic [1:0] sel_a, sel_b;
    logic [3*PW_A-1:0] st_a, dn_a;
    logic [3*PW_B-1:0] st_b, dn_b;
    logic next_ins, stall, jump_flag, jump_rel;
    logic [7:0] target;

    logic [PW_A-1:0] pc_a;
    logic ack_a, busy_a, err_a;
    logic [CW_A-1:0] cnt_a;
    logic [PW_B-1:0] pc_b;
    logic ack_b, busy_b, err_b;
    logic [CW_B-1:0] cnt_b;

    program_sequencer #(.PC_BITS(PW_A), .TGT_BITS(8), .NUM_PROGS(NP), .SEL_BITS(2), .CNT_BITS(CW_A)) dut_a (
        .clock(clock), .reset(reset), .req(req_a), .prog_sel(sel_a),
        .start_addrs(st_a), .done_addrs(dn_a), .next_ins(next_ins), .stall(stall),
        .jump_flag(jump_flag), .jump_rel(jump_rel), .target(target),
        .pc(pc_a), .ack(ack_a), .busy(busy_a), .err(err_a), .cycle_count(cnt_a)
    );

    program_sequencer #(.PC_BITS(PW_B), .TGT_BITS(8), .NUM_PROGS(NP), .SEL_BITS(2), .CNT_BITS(CW_B)) dut_b (
        .clock(clock), .reset(reset), .req(req_b), .prog_sel(sel_b),
        .start_addrs(st_b), .done_addrs(dn_b), .next_ins(next_ins), .stall(stall),
        .jump_flag(jump_flag), .jump_rel(jump_rel), .target(target),
        .pc(pc_b), .ack(ack_b), .busy(busy_b), .err(err_b), .cycle_count(cnt_b)
    );

    always #5 clock = ~clock;

    // Reference model: st 0 = waiting for request, 1 = running, 2 = finished/rejected.
    typedef struct {
        int st;
        int pc;
        int ack;
        int busy;
        int err;
        int cnt;
        int sel;
    } mdl_t;

    mdl_t ma, mb;
    int tsa[4], tda[4], tsb[4], tdb[4];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic mdl_t mzero();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int pw, input int cw, input logic rq,
                                   input int psel, input int ts[4], input int td[4]);
        mdl_t n;
        int pmod;
        int cmax;
        int off;
        n    = m;
        pmod = 1 << pw;
        cmax = (1 << cw) - 1;
        if (m.st == 0) begin
            if (rq) begin
                if (psel < NP) begin
                    n.st = 1; n.pc = ts[psel]; n.sel = psel; n.cnt = 0; n.err = 0; n.busy = 1;
                end else begin
                    n.st = 2; n.err = 1; n.ack = 1;
                end
            end
        end else if (m.st == 1) begin
            n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
            if (m.pc == td[m.sel]) begin
                n.busy = 0; n.ack = 1; n.st = 2;
            end else if (stall || !next_ins) begin
                n.pc = m.pc;
            end else if (jump_flag && jump_rel) begin
                off  = (int'(target) >= 128) ? int'(target) - 256 : int'(target);
                n.pc = ((m.pc + off) % pmod + pmod) % pmod;
            end else if (jump_flag) begin
                n.pc = int'(target) % pmod;
            end else begin
                n.pc = (m.pc + 1) % pmod;
            end
        end else begin
            if (!rq) begin
                n.ack = 0; n.st = 0;
            end
        end
        return n;
    endfunction

    task automatic cmp_all();
        chk("a_pc", 32'(pc_a), ma.pc);
        chk("a_ack", 32'(ack_a), ma.ack);
        chk("a_busy", 32'(busy_a), ma.busy);
        chk("a_err", 32'(err_a), ma.err);
        chk("a_cnt", 32'(cnt_a), ma.cnt);
        chk("b_pc", 32'(pc_b), mb.pc);
        chk("b_ack", 32'(ack_b), mb.ack);
        chk("b_busy", 32'(busy_b), mb.busy);
        chk("b_err", 32'(err_b), mb.err);
        chk("b_cnt", 32'(cnt_b), mb.cnt);
    endtask

    task automatic tick();
        mdl_t na, nb;
        na = mstep(ma, PW_A, CW_A, req_a, int'(sel_a), tsa, tda);
        nb = mstep(mb, PW_B, CW_B, req_b, int'(sel_b), tsb, tdb);
        @(posedge clock);
        #1;
        if (reset) begin
            ma = mzero();
            mb = mzero();
        end else begin
            ma = na;
            mb = nb;
        end
        cmp_all();
    endtask

    task automatic set_tabs();
        st_a = {10'(tsa[2]), 10'(tsa[1]), 10'(tsa[0])};
        dn_a = {10'(tda[2]), 10'(tda[1]), 10'(tda[0])};
        st_b = {4'(tsb[2]), 4'(tsb[1]), 4'(tsb[0])};
        dn_b = {4'(tdb[2]), 4'(tdb[1]), 4'(tdb[0])};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_a = 0; req_b = 0; sel_a = 0; sel_b = 0;
        next_ins = 0; stall = 0; jump_flag = 0; jump_rel = 0; target = 0;
        tsa = '{0, 10, 100, 0}; tda = '{20, 13, 100, 0};
        tsb = '{14, 0, 2, 0};   tdb = '{1, 12, 9, 0};
        set_tabs();
        ma = mzero();
        mb = mzero();
        #1;
        cmp_all();
        tick();
        reset = 1'b0;
        tick();

        // Basic fetch: program 1, start 10 done 13
        req_a = 1; sel_a = 1; next_ins = 1;
        tick(); chk("t1_pc_start", 32'(pc_a), 10); chk("t1_busy", 32'(busy_a), 1);
        tick(); chk("t1_pc11", 32'(pc_a), 11);
        tick(); chk("t1_pc12", 32'(pc_a), 12);
        tick(); chk("t1_pc13", 32'(pc_a), 13); chk("t1_no_ack_yet", 32'(ack_a), 0);
        tick(); chk("t1_ack", 32'(ack_a), 1); chk("t1_cnt", 32'(cnt_a), 4); chk("t1_busy_fall", 32'(busy_a), 0);
        tick(); chk("t1_ack_held", 32'(ack_a), 1);
        req_a = 0;
        tick(); chk("t1_ack_drop", 32'(ack_a), 0);

        // Relative then absolute jump, program 0
        req_a = 1; sel_a = 0;
        tick(); chk("t2_pc0", 32'(pc_a), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("t2_pc5", 32'(pc_a), 5);
        jump_flag = 1; jump_rel = 1; target = 8'hFE;
        tick(); chk("t2_rel_back", 32'(pc_a), 3);
        jump_flag = 0;
        tick(); chk("t2_pc4", 32'(pc_a), 4);
        jump_flag = 1; jump_rel = 0; target = 8'd20;
        tick(); chk("t2_abs", 32'(pc_a), 20);
        jump_flag = 0;
        tick(); chk("t2_ack", 32'(ack_a), 1);
        req_a = 0;
        tick();

        // Rejected selection, then a start==done program clears err
        req_a = 1; sel_a = 3;
        tick(); chk("t5_err", 32'(err_a), 1); chk("t5_ack", 32'(ack_a), 1); chk("t5_pc_keep", 32'(pc_a), 20);
        tick(); chk("t5_ack_held", 32'(ack_a), 1);
        req_a = 0;
        tick(); chk("t5_ack_drop", 32'(ack_a), 0); chk("t5_err_hold", 32'(err_a), 1);
        req_a = 1; sel_a = 2;
        tick(); chk("t6_err_clr", 32'(err_a), 0); chk("t6_pc", 32'(pc_a), 100); chk("t6_ack_early", 32'(ack_a), 0);
        tick(); chk("t6_ack", 32'(ack_a), 1); chk("t6_cnt1", 32'(cnt_a), 1);
        req_a = 0;
        tick();

        // Stall overrides next_ins and jump; counter keeps running; then async reset mid-run
        req_a = 1; sel_a = 0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t3_pc7", 32'(pc_a), 7); chk("t3_cnt7", 32'(cnt_a), 7);
        stall = 1; jump_flag = 1; jump_rel = 0; target = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t3_stall_pc", 32'(pc_a), 7);
        end
        chk("t3_cnt10", 32'(cnt_a), 10);
        stall = 0; jump_flag = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_pc12", 32'(pc_a), 12);
        #3;
        reset = 1'b1;
        #1;
        ma = mzero();
        mb = mzero();
        chk("t6_rst_pc", 32'(pc_a), 0); chk("t6_rst_busy", 32'(busy_a), 0); chk("t6_rst_ack", 32'(ack_a), 0);
        cmp_all();
        req_a = 0;
        tick();
        reset = 1'b0;
        tick();

        // Narrow instance: pc wrap, truncated absolute target, counter saturation
        req_b = 1; sel_b = 0; next_ins = 1;
        tick(); chk("t4_pc14", 32'(pc_b), 14);
        tick(); chk("t4_pc15", 32'(pc_b), 15);
        tick(); chk("t4_pc0", 32'(pc_b), 0);
        tick(); chk("t4_pc1", 32'(pc_b), 1);
        tick(); chk("t4_ack", 32'(ack_b), 1); chk("t4_cnt", 32'(cnt_b), 4);
        req_b = 0;
        tick();
        req_b = 1; sel_b = 1;
        tick(); tick(); tick();
        chk("t4_pc2", 32'(pc_b), 2);
        jump_flag = 1; jump_rel = 0; target = 8'hF5;
        tick(); chk("t4_trunc", 32'(pc_b), 5);
        jump_flag = 0;
        for (int i = 0; i < 20 && mb.st == 1; i++) tick();
        chk("t4_sat_ack", 32'(ack_b), 1); chk("t4_sat_cnt", 32'(cnt_b), 7);
        req_b = 0;
        tick();

        // Random programs against the model
        for (int p = 0; p < 30; p++) begin
            int budget;
            for (int i = 0; i < 3; i++) begin
                tsa[i] = int'($urandom_range(0, 1023));
                tda[i] = (tsa[i] + int'($urandom_range(0, 25))) % 1024;
            end
            set_tabs();
            req_a = 1;
            sel_a = 2'($urandom_range(0, 3));
            next_ins = 1; stall = 0; jump_flag = 0;
            tick();
            budget = 0;
            while (ma.st == 1 && budget < 3000) begin
                next_ins  = ($urandom_range(0, 3) != 0);
                stall     = ($urandom_range(0, 6) == 0);
                jump_flag = (budget < 20) && ($urandom_range(0, 11) == 0);
                jump_rel  = ($urandom_range(0, 3) != 0);
                if (jump_rel)
                    target = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'(256 - $urandom_range(1, 8));
                else
                    target = 8'($urandom);
                req_a = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 7) == 0) sel_a = 2'($urandom_range(0, 3));
                tick();
                budget++;
            end
            if (budget >= 3000) chk("rand_run_timeout", 1, 0);
            jump_flag = 0;
            if (ma.st == 2 && req_a) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
            end
            req_a = 0;
            tick();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
